// File: rtl/common.sv
// rtl/common.sv - shared dbus request/response types and responder FSM encoding
package common;

    localparam int DBUS_RESP_MAX_LATENCY = 15;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_resp_state_t;

endpackage

// File: rtl/dbus_resp_ram.sv
// rtl/dbus_resp_ram.sv - 64-bit word store, combinational read, byte-strobe synchronous write
module dbus_resp_ram #(
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       strobe,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - dbus responder: FSM, latency counter, address decode, response mux
// Build option: DBUS_RESP_LATENCY_EN enables the LATENCY-cycle WAIT phase (otherwise latency is 1).
module dbus_responder
    import common::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    dbus_resp_state_t state, state_n;
    logic             capture;
    logic [63:0]      addr_q, data_q;
    logic [7:0]       strobe_q;
    logic [63:0]      offset, word, rdata;
    logic             in_range, resp_fire, we;
    logic             unused_size;

    assign unused_size = ^dreq.size;

`ifdef DBUS_RESP_LATENCY_EN
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    logic [3:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt_n;
    end
`else
    logic unused_latency;
    assign unused_latency = ^32'(LATENCY);
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
`ifdef DBUS_RESP_LATENCY_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (dreq.valid) begin
                    capture = 1'b1;
`ifdef DBUS_RESP_LATENCY_EN
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        cnt_n   = '0;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_LOAD;
                    end
`else
                    state_n = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef DBUS_RESP_LATENCY_EN
                // A dropped valid means the core abandoned the access.
                if (!dreq.valid) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt <= 4'd1) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
`else
                state_n = IDLE;
`endif
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            strobe_q <= '0;
        end else if (capture) begin
            addr_q   <= dreq.addr;
            data_q   <= dreq.data;
            strobe_q <= dreq.strobe;
        end
    end

    // Full 64-bit compare so addresses far above the window cannot alias back into it.
    assign offset   = addr_q - BASE_ADDR;
    assign word     = offset >> 3;
    assign in_range = (addr_q >= BASE_ADDR) && (word < 64'(MEM_WORDS));

    assign resp_fire = (state == RESP) && dreq.valid;
    assign we        = resp_fire && in_range && (|strobe_q) && reset;

    dbus_resp_ram #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .idx    (word[IDX_W-1:0]),
        .strobe (strobe_q),
        .wdata  (data_q),
        .rdata  (rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = resp_fire;
        dresp.data_ok = resp_fire;
        dresp.data    = (resp_fire && in_range) ? rdata : 64'd0;
    end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - scoreboard bench for dbus_responder
module tb_dbus_responder;
    import common::*;

`ifdef DBUS_RESP_LATENCY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [63:0] data;
        logic        chk;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   last_ok_cyc = 0;
    logic mon_en = 1'b0;

    dbus_responder #(
        .MEM_WORDS (1024),
        .BASE_ADDR (64'h8000_0000),
        .LATENCY   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dresp.data_ok) begin
                if (sb.size() == 0) begin
                    chk("spurious_data_ok", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.due));
                    chk("addr_ok", 64'(dresp.addr_ok), 64'd1);
                    if (e.chk) chk("resp_data", dresp.data, e.data);
                end
            end else begin
                chk("idle_outputs", {63'(dresp.data), dresp.addr_ok}, 64'd0);
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("missing_data_ok", 64'(cyc), 64'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that ends RESP with valid low.
    task automatic req(input logic [63:0] addr, input logic [7:0] strobe,
                       input logic [63:0] data, input logic [63:0] exp, input logic is_read);
        int n;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strobe;
        dreq.data   = data;
        sb.push_back('{data: exp, chk: is_read, due: cyc + LAT});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dresp.data_ok && n < 40);
        if (n >= 40) chk("req_timeout", 64'(n), 64'd0);
        last_ok_cyc = cyc;
        @(posedge clk);
        #1;
        dreq.valid = 1'b0;
    endtask

    task automatic start_write(input logic [63:0] addr, input logic [63:0] data);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = 8'hFF;
        dreq.data   = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        dreq = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_addr_ok", 64'(dresp.addr_ok), 64'd0);
        chk("reset_data_ok", 64'(dresp.data_ok), 64'd0);
        chk("reset_data", dresp.data, 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        req(64'h8000_0010, 8'h00, 64'd0, 64'd0, 1'b1);
        req(64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b0);
        req(64'h8000_0008, 8'h00, 64'd0, 64'h0000_0000_CCCC_DDDD, 1'b1);
        req(64'h8000_000C, 8'hF0, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        req(64'h8000_000F, 8'h00, 64'd0, 64'h1122_3344_CCCC_DDDD, 1'b1);
        req(64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        req(64'h8000_0000, 8'h00, 64'd0, 64'd0, 1'b1);
        req(64'h8000_1FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
        req(64'h8000_1FF8, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1);
        req(64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        req(64'h8000_2000, 8'h00, 64'd0, 64'd0, 1'b1);
        req(64'h8000_0000, 8'h00, 64'd0, 64'd0, 1'b1);

        // Abort: valid dropped right after acceptance.
        start_write(64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF);
        dreq.valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        req(64'h8000_0008, 8'h00, 64'd0, 64'h1122_3344_CCCC_DDDD, 1'b1);

        // Reset while a write is in flight.
        start_write(64'h8000_0008, 64'h5555_5555_5555_5555);
        reset      = 1'b0;
        dreq.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_data_ok", 64'(dresp.data_ok), 64'd0);
        @(posedge clk);
        #1;
        req(64'h8000_0008, 8'h00, 64'd0, 64'h1122_3344_CCCC_DDDD, 1'b1);

        // Eight back-to-back reads.
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            req(64'h8000_1FF8, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1);
        end
        chk("b2b_span_cycles", 64'(last_ok_cyc - t0 + 1), 64'(8 * (LAT + 1)));

        repeat (6) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
